uart_alu_top: RTL and testbench

// - FPGA top level of the UART ALU: receives 3-byte commands on serial rx_i, computes an 8-bit ALU op,

---
 rtl/uart_alu_pkg.sv | 30 +++
 rtl/uart_alu_serdes.sv | 126 ++++++++++++
 rtl/uart_alu_top.sv | 142 ++++++++++++++
 tb/tb_uart_alu_top.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared definitions for the UART ALU.
//   - opcode byte values (OP_ADD .. OP_ECHO)
//   - parser state encoding
//   - bit_ticks(): clk cycles per serial bit for a given prescale
// Optional feature macro: UART_ALU_MUL_EN (consumed in uart_alu_top).
package uart_alu_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_MUL  = 8'h06;
    localparam logic [7:0] OP_ECHO = 8'hEC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_EXEC,
        ST_SEND_LO,
        ST_SEND_HI
    } state_e;

    // Host UART prescale semantics: one bit lasts 8*prescale clocks.
    function automatic int bit_ticks(input int prescale);
        return 8 * prescale;
    endfunction

endpackage

// File: rtl/uart_alu_serdes.sv
// uart_alu_serdes: 8N1 receiver and transmitter, LSB first, idle high.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   rx_i                 raw serial input (synchronised here)
//   tx_o                 serial output, 1 when idle or in reset
//   rx_valid_o/rx_data_o one-cycle pulse with a received byte (good stop bit)
//   rx_frame_err_o       one-cycle pulse when the stop bit sampled low
//   tx_valid_i/tx_data_i/tx_ready_o  byte handshake into the transmitter
module uart_alu_serdes
    import uart_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    output logic                  tx_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_frame_err_o,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o
);

    localparam int BIT  = bit_ticks(PRESCALE);
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);
    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH + 1);

    // ---------------- receiver ----------------
    logic                  rx_s1_q, rx_s2_q, rx_s3_q;
    logic                  rx_busy_q;
    logic [CW-1:0]         rx_cnt_q;
    logic [3:0]            rx_idx_q;   // 0 start, 1..8 data, 9 stop
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic                  rx_valid_q, rx_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            if (!rx_busy_q) begin
                // Falling edge only: a line held low after a bad stop bit
                // must return high before a new frame can start.
                if (rx_s3_q && !rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= CW'(HALF - 1);
                    rx_idx_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - 1'b1;
            end else begin
                rx_cnt_q <= CW'(BIT - 1);
                rx_idx_q <= rx_idx_q + 1'b1;
                if (rx_idx_q == '0) begin
                    if (rx_s2_q) rx_busy_q <= 1'b0;   // glitch, not a start bit
                end else if (rx_idx_q == LAST_IDX) begin
                    // Rearm at stop-bit centre so the next start edge is seen.
                    rx_busy_q  <= 1'b0;
                    rx_valid_q <= rx_s2_q;
                    rx_err_q   <= !rx_s2_q;
                end else begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
                end
            end
        end
    end

    assign rx_valid_o     = rx_valid_q;
    assign rx_data_o      = rx_shift_q;
    assign rx_frame_err_o = rx_err_q;

    // ---------------- transmitter ----------------
    logic                  tx_busy_q;
    logic [CW-1:0]         tx_cnt_q;
    logic [3:0]            tx_idx_q;
    logic [DATA_WIDTH+1:0] tx_shift_q;   // {stop, data, start}
    logic                  tx_last;

    // Ready in the final cycle of the stop bit so a queued byte's start
    // bit follows the stop bit with no idle gap.
    assign tx_last    = tx_busy_q && (tx_idx_q == LAST_IDX) && (tx_cnt_q == '0);
    assign tx_ready_o = !tx_busy_q || tx_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '1;
        end else if (tx_valid_i && tx_ready_o) begin
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= CW'(BIT - 1);
            tx_idx_q   <= '0;
            tx_shift_q <= {1'b1, tx_data_i, 1'b0};
        end else if (tx_busy_q) begin
            if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - 1'b1;
            end else if (tx_last) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_cnt_q   <= CW'(BIT - 1);
                tx_idx_q   <= tx_idx_q + 1'b1;
                tx_shift_q <= {1'b1, tx_shift_q[DATA_WIDTH+1:1]};
            end
        end
    end

    assign tx_o = tx_busy_q ? tx_shift_q[0] : 1'b1;

endmodule

// File: rtl/uart_alu_top.sv
// uart_alu_top: UART ALU. Receives {opcode, A, B} bytes on rx_i, computes a
// 16-bit result and returns R[7:0] then R[15:8] on tx_o (8N1, 8*PRESCALE
// clocks per bit).
// Ports:
//   clk   single clock, posedge
//   rst   asynchronous reset, active low
//   rx_i  serial input from host, idle high
//   tx_o  serial output to host, idle high
// Build option: define UART_ALU_MUL_EN to add opcode 0x06 (8x8 multiply);
// otherwise 0x06 is an unknown opcode.
module uart_alu_top #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic tx_o
);
    import uart_alu_pkg::*;

    logic                  rx_valid, rx_frame_err, tx_valid, tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [7:0]            tx_data;

    uart_alu_serdes #(
        .DATA_WIDTH (DATA_WIDTH),
        .PRESCALE   (PRESCALE)
    ) u_serdes (
        .clk_i          (clk),
        .rst_ni         (rst),
        .rx_i           (rx_i),
        .tx_o           (tx_o),
        .rx_valid_o     (rx_valid),
        .rx_data_o      (rx_data),
        .rx_frame_err_o (rx_frame_err),
        .tx_valid_i     (tx_valid),
        .tx_data_i      (tx_data),
        .tx_ready_o     (tx_ready)
    );

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ECHO: return 1'b1;
`ifdef UART_ALU_MUL_EN
            OP_MUL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] alu(input logic [7:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] ax, bx;
        ax = {8'h00, a};
        bx = {8'h00, b};
        case (op)
            OP_ADD:  return ax + bx;
            OP_SUB:  return ax - bx;
            OP_AND:  return ax & bx;
            OP_OR:   return ax | bx;
            OP_XOR:  return ax ^ bx;
`ifdef UART_ALU_MUL_EN
            OP_MUL:  return a * b;
`endif
            OP_ECHO: return {b, a};
            default: return 16'h0000;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d, a_q, a_d, b_q, b_d;
    logic [15:0] res_q, res_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Bytes arriving in EXEC/SEND_* are simply not consumed (no buffering).
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        tx_valid = 1'b0;
        tx_data  = res_q[7:0];
        case (state_q)
            ST_IDLE: begin
                // Unknown opcodes are dropped here, which lets the host resync.
                if (rx_valid && op_known(rx_data[7:0])) begin
                    op_d    = rx_data[7:0];
                    state_d = ST_GET_A;
                end
            end
            ST_GET_A: begin
                if (rx_frame_err) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    a_d     = rx_data[7:0];
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (rx_frame_err) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    b_d     = rx_data[7:0];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu(op_q, a_q, b_q);
                state_d = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = res_q[15:8];
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_alu_top.sv
// Directed bench for uart_alu_top at PRESCALE=1 (8 clocks per bit).
module tb_uart_alu_top;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_i = 1'b1;
    logic tx_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    uart_alu_top #(.DATA_WIDTH(8), .PRESCALE(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .rx_i (rx_i),
        .tx_o (tx_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host-side receiver: decodes tx_o into queues of byte / start time / stop bit.
    logic [7:0] rx_q[$];
    int         t_q[$];
    logic       stop_q[$];

    initial begin
        logic [7:0] bv;
        int         t0;
        forever begin
            @(negedge clk);
            if (rst && tx_o === 1'b0) begin
                t0 = cyc;
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    bv[i] = tx_o;
                end
                repeat (8) @(negedge clk);
                stop_q.push_back(tx_o);
                rx_q.push_back(bv);
                t_q.push_back(t0);
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx_i = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (8) @(negedge clk);
        end
        rx_i = stop;
        repeat (8) @(negedge clk);
        rx_i = 1'b1;
        if (!stop) repeat (16) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        send_frame(op, 1'b1);
        send_frame(a, 1'b1);
        send_frame(b, 1'b1);
    endtask

    // Waits (bounded) for two response bytes and pops them.
    task automatic get_resp(output bit ok, output logic [7:0] lo, output logic [7:0] hi,
                            output int gap, output logic stops);
        ok = 1'b0; lo = 'x; hi = 'x; gap = -1; stops = 1'b0;
        for (int i = 0; i < 600 && rx_q.size() < 2; i++) @(negedge clk);
        if (rx_q.size() >= 2) begin
            int t0, t1;
            ok    = 1'b1;
            lo    = rx_q.pop_front();
            hi    = rx_q.pop_front();
            t0    = t_q.pop_front();
            t1    = t_q.pop_front();
            gap   = t1 - t0;
            stops = stop_q.pop_front();
            stops = stops & stop_q.pop_front();
        end
    endtask

    task automatic flush();
        rx_q.delete(); t_q.delete(); stop_q.delete();
    endtask

    localparam int NV = 7;
    // {op, A, B, R[7:0], R[15:8]}
    localparam logic [7:0] VEC [NV][5] = '{
        '{8'h01, 8'h7F, 8'h02, 8'h81, 8'h00},
        '{8'h01, 8'hFF, 8'h01, 8'h00, 8'h01},
        '{8'h02, 8'h02, 8'h03, 8'hFF, 8'hFF},
        '{8'h03, 8'hF0, 8'h3C, 8'h30, 8'h00},
        '{8'h04, 8'hF0, 8'h0F, 8'hFF, 8'h00},
        '{8'h05, 8'hFF, 8'h0F, 8'hF0, 8'h00},
        '{8'hEC, 8'h12, 8'h34, 8'h12, 8'h34}
    };

    task automatic test_reset();
        bit saw_low;
        rst = 1'b0; rx_i = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_o); end
        rst = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) saw_low = 1'b1;
        end
        n_checks++;
        if (saw_low) begin n_fail++; $display("FAIL reset_idle tx_o went low after release, want 1"); end
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL reset_frames got %0d want 0", rx_q.size()); end
    endtask

    task automatic test_alu();
        bit ok; logic [7:0] lo, hi; int gap; logic st;
        for (int v = 0; v < NV; v++) begin
            send_cmd(VEC[v][0], VEC[v][1], VEC[v][2]);
            get_resp(ok, lo, hi, gap, st);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL alu%0d_timeout no response, want 2 bytes", v); end
            n_checks++;
            if (lo !== VEC[v][3]) begin n_fail++; $display("FAIL alu%0d_lo got %h want %h", v, lo, VEC[v][3]); end
            n_checks++;
            if (hi !== VEC[v][4]) begin n_fail++; $display("FAIL alu%0d_hi got %h want %h", v, hi, VEC[v][4]); end
            n_checks++;
            if (st !== 1'b1) begin n_fail++; $display("FAIL alu%0d_stop got %b want 1", v, st); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [7:0] lo, hi; int gap; logic st;
        send_cmd(8'h01, 8'h10, 8'h20);
        get_resp(ok, lo, hi, gap, st);
        n_checks++;
        if (gap != 80) begin n_fail++; $display("FAIL b2b_gap got %0d want 80", gap); end
        n_checks++;
        if (lo !== 8'h30 || hi !== 8'h00) begin n_fail++; $display("FAIL b2b_data got %h%h want 0030", hi, lo); end
    endtask

    task automatic test_mul();
        bit ok; logic [7:0] lo, hi; int gap; logic st;
        send_cmd(8'h06, 8'h10, 8'h10);
`ifdef UART_ALU_MUL_EN
        get_resp(ok, lo, hi, gap, st);
        n_checks++;
        if (!ok || lo !== 8'h00 || hi !== 8'h01) begin
            n_fail++; $display("FAIL mul got %h%h want 0100", hi, lo);
        end
`else
        repeat (300) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL mul_disabled got %0d bytes want 0", rx_q.size()); end
        flush();
`endif
        send_cmd(8'hEC, 8'h5A, 8'hC3);
        get_resp(ok, lo, hi, gap, st);
        n_checks++;
        if (!ok || lo !== 8'h5A || hi !== 8'hC3) begin
            n_fail++; $display("FAIL mul_then_echo got %h%h want C35A", hi, lo);
        end
    endtask

    task automatic test_unknown_op();
        bit ok; logic [7:0] lo, hi; int gap; logic st;
        send_frame(8'h55, 1'b1);
        send_cmd(8'hEC, 8'hA5, 8'h3C);
        get_resp(ok, lo, hi, gap, st);
        n_checks++;
        if (!ok || lo !== 8'hA5 || hi !== 8'h3C) begin
            n_fail++; $display("FAIL unknown_op got %h %h want a5 3c", lo, hi);
        end
        repeat (200) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL unknown_extra got %0d bytes want 0", rx_q.size()); end
    endtask

    task automatic test_frame_err();
        bit ok; logic [7:0] lo, hi; int gap; logic st;
        send_frame(8'h01, 1'b1);
        send_frame(8'h00, 1'b0);
        send_cmd(8'h03, 8'hF0, 8'h3C);
        get_resp(ok, lo, hi, gap, st);
        n_checks++;
        if (!ok || lo !== 8'h30 || hi !== 8'h00) begin
            n_fail++; $display("FAIL frame_err got %h %h want 30 00", lo, hi);
        end
        repeat (200) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL frame_err_extra got %0d bytes want 0", rx_q.size()); end
    endtask

    task automatic test_glitch();
        bit ok; logic [7:0] lo, hi; int gap; logic st;
        // Parser sits in GET_A while a 2-clock low pulse hits the line.
        send_frame(8'hEC, 1'b1);
        rx_i = 1'b0;
        repeat (2) @(negedge clk);
        rx_i = 1'b1;
        repeat (120) @(negedge clk);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        get_resp(ok, lo, hi, gap, st);
        n_checks++;
        if (!ok || lo !== 8'h3C || hi !== 8'hC3) begin
            n_fail++; $display("FAIL glitch got %h %h want 3c c3", lo, hi);
        end
    endtask

    task automatic test_reset_mid_tx();
        bit ok, seen; logic [7:0] lo, hi; int gap; logic st;
        send_cmd(8'hEC, 8'h00, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (tx_o === 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL midtx_start tx never went low, want start bit"); end
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (tx_o !== 1'b1) begin n_fail++; $display("FAIL midtx_reset got %b want 1", tx_o); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        flush();
        repeat (300) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0) begin n_fail++; $display("FAIL midtx_resume got %0d bytes want 0", rx_q.size()); end
        send_cmd(8'hEC, 8'h11, 8'h22);
        get_resp(ok, lo, hi, gap, st);
        n_checks++;
        if (!ok || lo !== 8'h11 || hi !== 8'h22) begin
            n_fail++; $display("FAIL midtx_recover got %h %h want 11 22", lo, hi);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_mul();
        test_unknown_op();
        test_frame_err();
        test_glitch();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
